// File: rtl/regfile_seq.sv
// Host-side sequencer for a 4 x 32-bit negedge register file: turns read, write and
// write-with-verify requests into posedge-timed bus cycles and returns one response each.
module regfile_seq #(
    parameter int D_SIZE = 31,
    parameter int A_W    = 2,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_verify,
    input  logic [A_W-1:0]    req_addr,
    input  logic [D_SIZE:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [D_SIZE:0]   rsp_data,
    output logic              rsp_err,
    output logic [ERR_W-1:0]  err_count,
    output logic [A_W-1:0]    bus_addr,
    output logic              bus_rw,
    output logic [D_SIZE:0]   bus_wdata,
    output logic              bus_oe,
    input  logic [D_SIZE:0]   bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t             state_q;
    logic               verify_q;
    logic [A_W-1:0]     bus_addr_q;
    logic [D_SIZE:0]    bus_wdata_q;
    logic               bus_rw_q;
    logic               bus_oe_q;
    logic               rsp_valid_q;
    logic [D_SIZE:0]    rsp_data_q;
    logic               rsp_err_q;
    logic [ERR_W-1:0]   err_count_q;

    logic               mismatch_d;
    logic [ERR_W-1:0]   err_count_d;

    // bus_wdata_q doubles as the latched write data for the verify compare
    assign mismatch_d  = verify_q && (bus_rdata != bus_wdata_q);
    assign err_count_d = (mismatch_d && (err_count_q != '1)) ? err_count_q + ERR_W'(1) : err_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            verify_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_rw_q    <= 1'b0;
            bus_oe_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        bus_addr_q <= req_addr;
                        verify_q   <= req_wr & req_verify;
                        if (req_wr) begin
                            bus_wdata_q <= req_wdata;
                            bus_rw_q    <= 1'b1;
                            bus_oe_q    <= 1'b1;
                            state_q     <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                WR: begin
                    bus_rw_q <= 1'b0;
                    bus_oe_q <= 1'b0;
                    if (verify_q) begin
                        state_q <= RD;
                    end else begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RD: begin
                    rsp_data_q  <= bus_rdata;
                    rsp_err_q   <= mismatch_d;
                    err_count_q <= err_count_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_count_q;
    assign bus_addr  = bus_addr_q;
    assign bus_rw    = bus_rw_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_oe    = bus_oe_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq with a behavioural negedge register file on the bus side.
module tb_regfile_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr, req_verify;
    logic [1:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [7:0]  err_count;
    logic [1:0]  bus_addr;
    logic        bus_rw, bus_oe;
    logic [31:0] bus_wdata, bus_rdata;

    logic [31:0] mem [4];
    logic [31:0] rf_out;
    logic [31:0] data_net;
    logic [31:0] force_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_verify(req_verify),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .err_count(err_count),
        .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_wdata(bus_wdata), .bus_oe(bus_oe),
        .bus_rdata(bus_rdata)
    );

    // Register file: writes from the data net or loads its output on the falling edge
    always @(negedge clk) begin
        if (bus_rw) mem[bus_addr] <= data_net;
        else        rf_out <= mem[bus_addr];
    end
    assign data_net  = bus_oe ? bus_wdata : rf_out;
    assign bus_rdata = data_net ^ force_mask;

    task automatic run_txn(input logic wr, input logic vf, input logic [1:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic er, output int lat, output int oe_n);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        req_valid = 1'b1; req_wr = wr; req_verify = vf; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wr = ~wr; req_verify = ~vf; req_addr = ~a; req_wdata = ~d;
        lat = 0; oe_n = 0;
        while (!rsp_valid && lat < 20) begin
            if (bus_oe) oe_n++;
            @(posedge clk); #1; lat++;
        end
        rd = rsp_data; er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_verify = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0; force_mask = '0;
        #1;
        checks++; if ({bus_rw, bus_oe, rsp_valid, rsp_err} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {bus_rw, bus_oe, rsp_valid, rsp_err}); end
        checks++; if (bus_addr !== 2'd0 || bus_wdata !== 32'd0) begin errors++; $display("FAIL reset_bus: got addr %0d wdata %h expected 0 0", bus_addr, bus_wdata); end
        checks++; if (rsp_data !== 32'd0 || err_count !== 8'd0) begin errors++; $display("FAIL reset_rsp: got data %h cnt %h expected 0 0", rsp_data, err_count); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er; int lat, oe_n;
        run_txn(1'b1, 1'b0, 2'd2, 32'hDEADBEEF, rd, er, lat, oe_n);
        checks++; if (lat !== 1) begin errors++; $display("FAIL basic_wr_lat: got %0d expected 1", lat); end
        checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL basic_wr_rsp: got %h/%b expected 0/0", rd, er); end
        checks++; if (oe_n !== 1) begin errors++; $display("FAIL basic_wr_oe: got %0d expected 1", oe_n); end
        run_txn(1'b0, 1'b0, 2'd2, 32'h0, rd, er, lat, oe_n);
        checks++; if (lat !== 1) begin errors++; $display("FAIL basic_rd_lat: got %0d expected 1", lat); end
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL basic_rd_rsp: got %h/%b expected deadbeef/0", rd, er); end
        checks++; if (oe_n !== 0) begin errors++; $display("FAIL basic_rd_oe: got %0d expected 0", oe_n); end
    endtask

    task automatic test_all_addrs();
        logic [31:0] rd; logic er; int lat, oe_n;
        logic [31:0] vals [4];
        vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333; vals[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b0, 2'(i), vals[i], rd, er, lat, oe_n);
            checks++; if (oe_n !== 1) begin errors++; $display("FAIL all_wr_oe[%0d]: got %0d expected 1", i, oe_n); end
        end
        for (int i = 3; i >= 0; i--) begin
            run_txn(1'b0, 1'b0, 2'(i), 32'h0, rd, er, lat, oe_n);
            checks++; if (rd !== vals[i]) begin errors++; $display("FAIL all_rd[%0d]: got %h expected %h", i, rd, vals[i]); end
        end
    endtask

    task automatic test_verify_ok();
        logic [31:0] rd; logic er; int lat, oe_n;
        run_txn(1'b1, 1'b1, 2'd1, 32'hA5A5A5A5, rd, er, lat, oe_n);
        checks++; if (lat !== 2) begin errors++; $display("FAIL vok_lat: got %0d expected 2", lat); end
        checks++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin errors++; $display("FAIL vok_rsp: got %h/%b expected a5a5a5a5/0", rd, er); end
        checks++; if (err_count !== 8'd0 || oe_n !== 1) begin errors++; $display("FAIL vok_cnt_oe: got %h/%0d expected 00/1", err_count, oe_n); end
    endtask

    task automatic test_verify_mismatch();
        logic [31:0] rd; logic er; int lat, oe_n;
        force_mask = 32'h1;
        run_txn(1'b1, 1'b1, 2'd1, 32'hA5A5A5A5, rd, er, lat, oe_n);
        checks++; if (rd !== 32'hA5A5A5A4 || er !== 1'b1) begin errors++; $display("FAIL vbad_rsp: got %h/%b expected a5a5a5a4/1", rd, er); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL vbad_cnt1: got %h expected 01", err_count); end
        for (int i = 0; i < 253; i++) run_txn(1'b1, 1'b1, 2'd0, 32'h0F0F0F0F, rd, er, lat, oe_n);
        checks++; if (err_count !== 8'hFE) begin errors++; $display("FAIL vbad_cnt254: got %h expected fe", err_count); end
        run_txn(1'b1, 1'b1, 2'd0, 32'h0F0F0F0F, rd, er, lat, oe_n);
        checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL vbad_cnt255: got %h expected ff", err_count); end
        for (int i = 0; i < 5; i++) begin
            run_txn(1'b1, 1'b1, 2'd0, 32'h0F0F0F0F, rd, er, lat, oe_n);
            checks++; if (er !== 1'b1 || err_count !== 8'hFF) begin errors++; $display("FAIL vbad_sat[%0d]: got %b/%h expected 1/ff", i, er, err_count); end
        end
        run_txn(1'b0, 1'b1, 2'd1, 32'h0, rd, er, lat, oe_n);
        checks++; if (rd !== 32'hA5A5A5A4 || er !== 1'b0 || lat !== 1) begin errors++; $display("FAIL vrd_ignored: got %h/%b/%0d expected a5a5a5a4/0/1", rd, er, lat); end
        force_mask = 32'h0;
        run_txn(1'b1, 1'b0, 2'd0, 32'h11111111, rd, er, lat, oe_n);
        checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL vbad_plain_after: got %h/%b expected 0/0", rd, er); end
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1; req_wr = 1'b0; req_verify = 1'b0; req_addr = 2'd0; req_wdata = '0;
        @(posedge clk); #1;
        req_addr = 2'd3;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_rd: got %b expected 0", req_ready); end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h11111111 || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h rdy=%b expected 1/11111111/0", i, rsp_valid, rsp_data, req_ready); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_idle: got v=%b rdy=%b expected 0/1", rsp_valid, req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_accept2: got %b expected 0", req_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h44444444) begin errors++; $display("FAIL bp_rsp2: got %b/%h expected 1/44444444", rsp_valid, rsp_data); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd; logic er; int lat, oe_n;
        req_valid = 1'b1; req_wr = 1'b1; req_verify = 1'b0; req_addr = 2'd3; req_wdata = 32'h99999999;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (bus_oe !== 1'b1 || bus_rw !== 1'b1) begin errors++; $display("FAIL rmw_in_wr: got oe=%b rw=%b expected 1/1", bus_oe, bus_rw); end
        rst = 1'b1;
        #1;
        checks++; if (bus_oe !== 1'b0 || bus_rw !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rmw_drop: got oe=%b rw=%b v=%b expected 0/0/0", bus_oe, bus_rw, rsp_valid); end
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmw_no_rsp[%0d]: got %b expected 0", i, rsp_valid); end
            @(posedge clk); #1;
        end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rmw_cnt: got %h expected 00", err_count); end
        run_txn(1'b0, 1'b0, 2'd3, 32'h0, rd, er, lat, oe_n);
        checks++; if (rd !== 32'h44444444 || lat !== 1) begin errors++; $display("FAIL rmw_prior: got %h/%0d expected 44444444/1", rd, lat); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        rf_out = 32'h0;
        test_reset();
        test_basic();
        test_all_addrs();
        test_verify_ok();
        test_verify_mismatch();
        test_backpressure();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
